// File: rtl/stm1_deframer.sv
// STM-1 receive frame aligner: hunts and tracks the A1/A2 framing word, strips
// the section-overhead columns and emits VC4 payload bytes tagged with row/column.
module stm1_deframer #(
    parameter int unsigned LENGTH     = 270,
    parameter int unsigned WIDTH      = 9,
    parameter int unsigned OH_COLS    = 9,
    parameter logic [7:0]  A1_BYTE    = 8'hF6,
    parameter logic [7:0]  A2_BYTE    = 8'h28,
    parameter int unsigned LOF_THRESH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  din,
    input  logic        din_valid,
    output logic [7:0]  pay_data,
    output logic        pay_valid,
    output logic        pay_sof,
    output logic        pay_eof,
    output logic [3:0]  pay_row,
    output logic [8:0]  pay_col,
    output logic        in_frame,
    output logic        lof,
    output logic [15:0] frame_cnt
);
    localparam int unsigned      BAD_W     = $clog2(LOF_THRESH + 1);
    localparam logic [8:0]       COL_LAST  = 9'(LENGTH - 1);
    localparam logic [3:0]       ROW_LAST  = 4'(WIDTH - 1);
    localparam logic [8:0]       COL_OH    = 9'(OH_COLS);
    localparam logic [8:0]       COL_FAS   = 9'd5;
    localparam logic [47:0]      FAS_WORD  = {A1_BYTE, A1_BYTE, A1_BYTE, A2_BYTE, A2_BYTE, A2_BYTE};
    localparam logic [BAD_W-1:0] BAD_LIMIT = BAD_W'(LOF_THRESH);

    typedef enum logic [1:0] {HUNT, PRESYNC, SYNC} state_t;

    state_t           state_q, state_d;
    logic [3:0]       row_q, row_d;
    logic [8:0]       col_q, col_d;
    logic [BAD_W-1:0] bad_q, bad_d, bad_inc;
    // Five previous valid bytes; din completes the six-byte framing window.
    logic [39:0]      hist_q, hist_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic [7:0]       pay_data_q, pay_data_d;
    logic             pay_valid_q, pay_valid_d;
    logic             pay_sof_q, pay_sof_d;
    logic             pay_eof_q, pay_eof_d;
    logic [3:0]       pay_row_q, pay_row_d;
    logic [8:0]       pay_col_q, pay_col_d;
    logic             in_frame_q, in_frame_d;
    logic             lof_q, lof_d;
    logic             fas_ok, at_fas, at_pay;

    assign fas_ok  = ({hist_q, din} == FAS_WORD);
    assign at_fas  = (row_q == '0) && (col_q == COL_FAS);
    assign at_pay  = (col_q >= COL_OH);
    assign bad_inc = bad_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            row_q       <= '0;
            col_q       <= '0;
            bad_q       <= '0;
            hist_q      <= '0;
            frame_cnt_q <= '0;
            pay_data_q  <= '0;
            pay_valid_q <= 1'b0;
            pay_sof_q   <= 1'b0;
            pay_eof_q   <= 1'b0;
            pay_row_q   <= '0;
            pay_col_q   <= '0;
            in_frame_q  <= 1'b0;
            lof_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            bad_q       <= bad_d;
            hist_q      <= hist_d;
            frame_cnt_q <= frame_cnt_d;
            pay_data_q  <= pay_data_d;
            pay_valid_q <= pay_valid_d;
            pay_sof_q   <= pay_sof_d;
            pay_eof_q   <= pay_eof_d;
            pay_row_q   <= pay_row_d;
            pay_col_q   <= pay_col_d;
            in_frame_q  <= in_frame_d;
            lof_q       <= lof_d;
        end
    end

    // row/col hold the position of the byte currently on din.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        bad_d       = bad_q;
        hist_d      = hist_q;
        frame_cnt_d = frame_cnt_q;
        if (din_valid) begin
            hist_d = {hist_q[31:0], din};
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 4'd1;
            end else begin
                col_d = col_q + 9'd1;
            end
            unique case (state_q)
                HUNT: begin
                    if (fas_ok) begin
                        state_d = PRESYNC;
                        row_d   = '0;
                        col_d   = COL_FAS + 9'd1;
                    end
                end
                PRESYNC: begin
                    if (at_fas) begin
                        if (fas_ok) begin
                            state_d     = SYNC;
                            bad_d       = '0;
                            frame_cnt_d = frame_cnt_q + 16'd1;
                        end else begin
                            state_d = HUNT;
                        end
                    end
                end
                SYNC: begin
                    if (at_fas) begin
                        if (fas_ok) begin
                            bad_d       = '0;
                            frame_cnt_d = frame_cnt_q + 16'd1;
                        end else if (bad_inc == BAD_LIMIT) begin
                            state_d = HUNT;
                            bad_d   = '0;
                        end else begin
                            bad_d = bad_inc;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_comb begin
        pay_data_d  = pay_data_q;
        pay_row_d   = pay_row_q;
        pay_col_d   = pay_col_q;
        pay_valid_d = 1'b0;
        pay_sof_d   = 1'b0;
        pay_eof_d   = 1'b0;
        in_frame_d  = (state_d == SYNC);
        lof_d       = (state_q == SYNC) && (state_d == HUNT);
        if (din_valid && (state_q == SYNC) && at_pay) begin
            pay_valid_d = 1'b1;
            pay_data_d  = din;
            pay_row_d   = row_q;
            pay_col_d   = col_q - COL_OH;
            pay_sof_d   = (row_q == '0) && (col_q == COL_OH);
            pay_eof_d   = (row_q == ROW_LAST) && (col_q == COL_LAST);
        end
    end

    assign pay_data  = pay_data_q;
    assign pay_valid = pay_valid_q;
    assign pay_sof   = pay_sof_q;
    assign pay_eof   = pay_eof_q;
    assign pay_row   = pay_row_q;
    assign pay_col   = pay_col_q;
    assign in_frame  = in_frame_q;
    assign lof       = lof_q;
    assign frame_cnt = frame_cnt_q;

endmodule
